// File: rtl/c2f_pdumeta_buffer_if.sv
// ---------------------------------------------------------------------------
// c2f_pdumeta_buffer_if
// Handshake bundle between the PCIe fetch stage, the PDU metadata buffer and
// the downstream flow/queue logic.
//   in_data / in_valid   : entry from the fetch stage (no ready returned)
//   out_data / out_valid : head entry presented downstream
//   out_ready            : downstream accepts out_data this cycle
// Modports: master = producer/consumer side, slave = the buffer.
// ---------------------------------------------------------------------------
interface c2f_pdumeta_buffer_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/c2f_pdumeta_buffer.sv
// ---------------------------------------------------------------------------
// c2f_pdumeta_buffer
// FIFO for PDU metadata entries between the CPU-to-FPGA fetch stage and the
// flow/queue logic. Storage is a DEPTH-1 entry dual-port RAM plus one output
// register (total capacity DEPTH) and a one-entry skid slot that catches the
// RAM read when the output register stalls. Writes arriving while full are
// dropped and counted.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : in_data/in_valid, out_data/out_valid/out_ready
//   pdumeta_cnt  : registered occupancy (RAM entries + skid + output register)
//   overflow     : sticky, set when an entry was dropped
//   drop_cnt     : dropped entries, saturating at 16'hFFFF
// Optional (define PDUMETA_BUFFER_STATS_EN):
//   push_total, pop_total : wrapping 32-bit accept/pop counters
//   max_cnt               : high-water mark of pdumeta_cnt
// ---------------------------------------------------------------------------
module c2f_pdumeta_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 512,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    c2f_pdumeta_buffer_if.slave    bus,
    output logic [CNT_WIDTH-1:0]   pdumeta_cnt,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
`ifdef PDUMETA_BUFFER_STATS_EN
    ,
    output logic [31:0]            push_total,
    output logic [31:0]            pop_total,
    output logic [CNT_WIDTH-1:0]   max_cnt
`endif
);

    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [AW-1:0]        PTR_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0]        PTR_ZERO = AW'(0);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);

    // Pointers wrap at the RAM depth, which is not a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CNT_WIDTH-1:0]  ram_cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  skid_valid_r;
    logic                  overflow_r;
    logic [15:0]           drop_cnt_r;

    logic                  pop_s;
    logic                  out_free_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [CNT_WIDTH-1:0]  cnt_next_s;
    logic [CNT_WIDTH-1:0]  ram_cnt_next_s;

    assign pop_s      = out_valid_r & bus.out_ready;
    assign out_free_s = ~out_valid_r | bus.out_ready;
    // cnt_r never exceeds DEPTH, so "not full" is "less than DEPTH".
    assign accept_s   = bus.in_valid & ((cnt_r != FULL_CNT) | pop_s);
    assign drop_s     = bus.in_valid & ~accept_s;
    // A read is issued whenever the RAM has data and the skid slot is free:
    // the data lands in the output register if it is free, else in the skid.
    // Keeping the read decision independent of out_ready while the skid is
    // empty is what lets back-to-back streaming run without bubbles.
    assign rd_en_s    = (ram_cnt_r != CNT_ZERO) & ~skid_valid_r;
    assign rd_data_s  = mem_r[rd_ptr_r];

    // Occupancy update for the whole buffer and for the RAM alone.
    always_comb begin
        cnt_next_s     = cnt_r;
        ram_cnt_next_s = ram_cnt_r;
        case ({accept_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + CNT_ONE;
            2'b01:   cnt_next_s = cnt_r - CNT_ONE;
            default: cnt_next_s = cnt_r;
        endcase
        case ({accept_s, rd_en_s})
            2'b10:   ram_cnt_next_s = ram_cnt_r + CNT_ONE;
            2'b01:   ram_cnt_next_s = ram_cnt_r - CNT_ONE;
            default: ram_cnt_next_s = ram_cnt_r;
        endcase
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers, counters, output register, skid slot and drop tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            ram_cnt_r    <= CNT_ZERO;
            cnt_r        <= CNT_ZERO;
            out_data_r   <= {DATA_WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            skid_data_r  <= {DATA_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            drop_cnt_r   <= 16'h0000;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            ram_cnt_r <= ram_cnt_next_s;
            cnt_r     <= cnt_next_s;

            // The skid entry is older than any RAM read, so it refills first;
            // rd_en_s is low whenever the skid is occupied.
            if (out_free_s) begin
                if (skid_valid_r) begin
                    out_data_r   <= skid_data_r;
                    out_valid_r  <= 1'b1;
                    skid_valid_r <= 1'b0;
                end else if (rd_en_s) begin
                    out_data_r   <= rd_data_s;
                    out_valid_r  <= 1'b1;
                end else begin
                    out_valid_r  <= 1'b0;
                end
            end else if (rd_en_s) begin
                skid_data_r  <= rd_data_s;
                skid_valid_r <= 1'b1;
            end

            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'h0001;
                end
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign pdumeta_cnt   = cnt_r;
    assign overflow      = overflow_r;
    assign drop_cnt      = drop_cnt_r;

`ifdef PDUMETA_BUFFER_STATS_EN
    logic [31:0]          push_total_r;
    logic [31:0]          pop_total_r;
    logic [CNT_WIDTH-1:0] max_cnt_r;

    // Accept/pop totals and occupancy high-water mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_total_r <= 32'h0000_0000;
            pop_total_r  <= 32'h0000_0000;
            max_cnt_r    <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                push_total_r <= push_total_r + 32'h0000_0001;
            end
            if (pop_s) begin
                pop_total_r <= pop_total_r + 32'h0000_0001;
            end
            if (cnt_next_s > max_cnt_r) begin
                max_cnt_r <= cnt_next_s;
            end else begin
                max_cnt_r <= max_cnt_r;
            end
        end
    end

    assign push_total = push_total_r;
    assign pop_total  = pop_total_r;
    assign max_cnt    = max_cnt_r;
`endif

endmodule

// File: tb/tb_c2f_pdumeta_buffer.sv
// ---------------------------------------------------------------------------
// tb_c2f_pdumeta_buffer
// Randomised and directed stimulus against a queue-based reference model.
// The model process (negedge) decides acceptance from the occupancy rules,
// pushes accepted entries with their acceptance cycle, and checks the DUT:
// out_valid must be high exactly when the oldest entry is at least two
// cycles old, and whenever it is high out_data must equal that entry.
// ---------------------------------------------------------------------------
module tb_c2f_pdumeta_buffer;

    localparam int DW    = 128;
    localparam int DEPTH = 512;
    localparam int CW    = 10;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] pdumeta_cnt;
    logic          overflow;
    logic [15:0]   drop_cnt;
`ifdef PDUMETA_BUFFER_STATS_EN
    logic [31:0]   push_total;
    logic [31:0]   pop_total;
    logic [CW-1:0] max_cnt;
`endif

    c2f_pdumeta_buffer_if #(.DATA_WIDTH(DW)) bus ();

    c2f_pdumeta_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pdumeta_cnt(pdumeta_cnt),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
`ifdef PDUMETA_BUFFER_STATS_EN
        ,
        .push_total (push_total),
        .pop_total  (pop_total),
        .max_cnt    (max_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    int   m_cnt   = 0;
    int   m_drop  = 0;
    logic m_ovf   = 1'b0;
    int   m_push  = 0;
    int   m_pop   = 0;
    int   m_max   = 0;
    int   n_pops  = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;
    logic m_clear = 1'b0;
    logic ev, popm, accm;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_clear) begin
                q.delete();
                m_cnt = 0; m_drop = 0; m_ovf = 1'b0;
                m_push = 0; m_pop = 0; m_max = 0;
                m_clear = 1'b0;
            end
            cyc++;
            ev = (q.size() > 0) && (q[0].t <= cyc - 2);
            chk("out_valid", DW'(bus.out_valid), DW'(ev));
            if (ev) chk("out_data", bus.out_data, q[0].d);
            chk("pdumeta_cnt", DW'(pdumeta_cnt), DW'(m_cnt));
            chk("overflow", DW'(overflow), DW'(m_ovf));
            chk("drop_cnt", DW'(drop_cnt), DW'(m_drop));
`ifdef PDUMETA_BUFFER_STATS_EN
            chk("push_total", DW'(push_total), DW'(m_push));
            chk("pop_total", DW'(pop_total), DW'(m_pop));
            chk("max_cnt", DW'(max_cnt), DW'(m_max));
`endif
            popm = ev && bus.out_ready;
            accm = bus.in_valid && (m_cnt < DEPTH || (m_cnt == DEPTH && popm));
            if (popm) begin
                void'(q.pop_front());
                m_cnt--; m_pop++; n_pops++;
            end
            if (accm) begin
                q.push_back('{d: bus.in_data, t: cyc});
                m_cnt++; m_push++;
            end else if (bus.in_valid) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (m_cnt > m_max) m_max = m_cnt;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic drain(input string nm, input int limit);
        int n;
        n = 0;
        do begin
            step(1'b0, '0, 1'b1);
            n++;
        end while (m_cnt != 0 && n < limit);
        if (m_cnt != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: model still holds %0d entries after %0d cycles", nm, m_cnt, limit);
        end
        chk({nm, "_cnt"}, DW'(pdumeta_cnt), DW'(0));
    endtask

    initial begin
        int pops0, peak, pushes, guard;
        logic [15:0] drop0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_cnt", DW'(pdumeta_cnt), DW'(0));
        chk("rst_overflow", DW'(overflow), DW'(0));
        chk("rst_drop", DW'(drop_cnt), DW'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        // Fill past capacity with the output stalled, then drain.
        for (int i = 0; i < 515; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("fill_cnt", DW'(pdumeta_cnt), DW'(512));
        chk("fill_overflow", DW'(overflow), DW'(1));
        chk("fill_drop", DW'(drop_cnt), DW'(3));
        pops0 = n_pops;
        drain("fill_drain", 700);
        chk("fill_pops", DW'(n_pops - pops0), DW'(512));
`ifdef PDUMETA_BUFFER_STATS_EN
        chk("stat_push", DW'(push_total), DW'(512));
        chk("stat_pop", DW'(pop_total), DW'(512));
        chk("stat_max", DW'(max_cnt), DW'(512));
`endif

        // Single entry latency.
        step(1'b1, DW'(8'hA5), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("single_cnt1", DW'(pdumeta_cnt), DW'(1));
        step(1'b0, '0, 1'b1);
        chk("single_valid", DW'(bus.out_valid), DW'(1));
        chk("single_data", bus.out_data, DW'(8'hA5));
        step(1'b0, '0, 1'b1);
        chk("single_cnt0", DW'(pdumeta_cnt), DW'(0));

        // Streaming 1000 back-to-back entries.
        peak = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, DW'(32'h1000 + i), 1'b1);
            if (int'(pdumeta_cnt) > peak) peak = int'(pdumeta_cnt);
        end
        drain("stream_drain", 20);
        chk("stream_peak_le3", DW'(peak <= 3), DW'(1));

        // Full buffer with simultaneous push and pop.
        for (int i = 0; i < 512; i++) step(1'b1, DW'(32'h2000 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("full_cnt", DW'(pdumeta_cnt), DW'(512));
        drop0 = drop_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(32'h3000 + i), 1'b1);
            if (i > 0) chk("full_pp_cnt", DW'(pdumeta_cnt), DW'(512));
        end
        step(1'b0, '0, 1'b0);
        chk("full_pp_cnt_end", DW'(pdumeta_cnt), DW'(512));
        chk("full_pp_drop", DW'(drop_cnt), DW'(drop0));
        drain("full_drain", 700);

        // Random valid/ready traffic.
        pushes = 0;
        guard  = 0;
        while (pushes < 5000 && guard < 20000) begin
            logic v;
            v = ($urandom_range(0, 9) < 6);
            step(v, {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 7));
            if (v) pushes++;
            guard++;
        end
        if (pushes < 5000) begin
            total++; bad++;
            $display("FAIL rand_timeout: only %0d pushes issued", pushes);
        end
        drain("rand_drain", 700);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 200; i++) step(1'b1, DW'(32'h4000 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("pre_rst_cnt", DW'(pdumeta_cnt), DW'(200));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", DW'(bus.out_valid), DW'(0));
        chk("async_rst_cnt", DW'(pdumeta_cnt), DW'(0));
        #1 rst = 1'b0;
        m_clear = 1'b1;
        step(1'b1, DW'(1), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("post_rst_valid", DW'(bus.out_valid), DW'(1));
        chk("post_rst_data", bus.out_data, DW'(1));
        drain("post_rst_drain", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
